// File: rtl/ysyx_22041752_seq_divider_if.sv
// Operand/result handshake bundle between the EX stage and the sequential divider.
interface ysyx_22041752_seq_divider_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             div_signed;
  logic             div_word;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  modport master (
    output in_valid, div_signed, div_word, x, y, out_ready,
    input  in_ready, out_valid, quo, rem
  );

  modport slave (
    input  in_valid, div_signed, div_word, x, y, out_ready,
    output in_ready, out_valid, quo, rem
  );
endinterface

// File: rtl/ysyx_22041752_seq_divider.sv
// Multi-cycle radix-2 restoring divider with signed/unsigned and RV64 word modes.
//   state | meaning
//   IDLE  | ready for operands
//   CALC  | one quotient bit per cycle, MSB first
//   DONE  | result held on quo/rem until the consumer takes it
module ysyx_22041752_seq_divider #(
  parameter int WIDTH   = 64,
  parameter bit WORD_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  input logic flush,
  ysyx_22041752_seq_divider_if.slave bus
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    N_FULL   = CW'(WIDTH);
  localparam logic [CW-1:0]    N_WORD   = CW'(HALF);
  localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_WORD = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dsr, rmd, quo_r, rem_r;
  logic             neg_q, neg_r, word_r;

  logic             accept, word_sel, x_neg, y_neg, y_zero, ovf, special;
  logic [WIDTH-1:0] x_ext, y_ext, x_sx, x_mag, y_mag, dvd_init, quo_sp, rem_sp;

  logic [WIDTH:0]   r_sh, trial;
  logic [WIDTH-1:0] rmd_nx, dvd_nx, q_mag, q_fix, r_fix, quo_fin, rem_fin;

  // flush suppresses any accept in the same cycle
  assign accept   = (state == IDLE) && bus.in_valid && !flush;
  assign word_sel = WORD_EN && bus.div_word;

  // Operand prep: extend to full width, take magnitudes, detect the no-iteration cases
  always_comb begin
    if (word_sel) begin
      x_ext = {{HALF{bus.div_signed & bus.x[HALF-1]}}, bus.x[HALF-1:0]};
      y_ext = {{HALF{bus.div_signed & bus.y[HALF-1]}}, bus.y[HALF-1:0]};
      x_sx  = {{HALF{bus.x[HALF-1]}}, bus.x[HALF-1:0]};
    end else begin
      x_ext = bus.x;
      y_ext = bus.y;
      x_sx  = bus.x;
    end
    x_neg    = bus.div_signed & x_ext[WIDTH-1];
    y_neg    = bus.div_signed & y_ext[WIDTH-1];
    x_mag    = x_neg ? -x_ext : x_ext;
    y_mag    = y_neg ? -y_ext : y_ext;
    // word mode parks the dividend in the upper half so the MSB-first shift is mode-independent
    dvd_init = word_sel ? {x_mag[HALF-1:0], {HALF{1'b0}}} : x_mag;
    y_zero   = (y_ext == '0);
    ovf      = bus.div_signed && (y_ext == '1) &&
               (x_ext == (word_sel ? MIN_WORD : MIN_FULL));
    special  = y_zero || ovf;
    // word results are always sign-extended from the op width, even unsigned
    quo_sp   = y_zero ? '1 : x_sx;
    rem_sp   = y_zero ? x_sx : '0;
  end

  // One restoring step plus sign fix-up of the final result
  always_comb begin
    r_sh    = {rmd, dvd[WIDTH-1]};
    trial   = r_sh - {1'b0, dsr};
    rmd_nx  = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_nx  = {dvd[WIDTH-2:0], ~trial[WIDTH]};
    q_mag   = word_r ? {{HALF{1'b0}}, dvd_nx[HALF-1:0]} : dvd_nx;
    q_fix   = neg_q ? -q_mag : q_mag;
    r_fix   = neg_r ? -rmd_nx : rmd_nx;
    quo_fin = word_r ? {{HALF{q_fix[HALF-1]}}, q_fix[HALF-1:0]} : q_fix;
    rem_fin = word_r ? {{HALF{r_fix[HALF-1]}}, r_fix[HALF-1:0]} : r_fix;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; CALC ends on the terminal count of the down-counter
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Datapath: latch operands on accept, iterate in CALC, register the result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rmd    <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      word_r <= 1'b0;
    end else if (accept) begin
      word_r <= word_sel;
      neg_q  <= x_neg ^ y_neg;
      neg_r  <= x_neg;
      dvd    <= dvd_init;
      dsr    <= y_mag;
      rmd    <= '0;
      cnt    <= word_sel ? N_WORD : N_FULL;
      if (special) begin
        quo_r <= quo_sp;
        rem_r <= rem_sp;
      end
    end else if (state == CALC && !flush) begin
      dvd <= dvd_nx;
      rmd <= rmd_nx;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        quo_r <= quo_fin;
        rem_r <= rem_fin;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quo       = quo_r;
  assign bus.rem       = rem_r;
endmodule

// File: tb/tb_ysyx_22041752_seq_divider.sv
// Bench for the sequential divider: vector table, handshake/flush/reset corners, random ops.
module tb_ysyx_22041752_seq_divider;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random
  logic ov_prev = 1'b0;

  typedef struct {
    logic        s;
    logic        w;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          t0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  ysyx_22041752_seq_divider_if #(.WIDTH(64)) bus ();

  ysyx_22041752_seq_divider #(.WIDTH(64), .WORD_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: chooses out_ready, checks latency on the rising out_valid, compares on handshake
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (bus.out_valid === 1'b1 && ov_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid got=1 exp=0 at cyc=%0d", cyc);
      end else begin
        chk("latency", 64'(cyc - sb[0].t0), 64'(sb[0].lat));
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready && sb.size() > 0) begin
      chk("quo", bus.quo, sb[0].q);
      chk("rem", bus.rem, sb[0].r);
      void'(sb.pop_front());
    end
    ov_prev = bus.out_valid;
  end

  // Reference model written with native SV division
  task automatic ref_div(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      lat = 1;
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); lat = 33;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32; lat = 33;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      lat = 1;
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0;
      end else if (s) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); lat = 65;
      end else begin
        q = a / b; r = a % b; lat = 65;
      end
    end
  endtask

  task automatic issue(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] q, input logic [63:0] r, input int lat, input bit track);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL issue_wait got=in_ready_low exp=in_ready_high");
      return;
    end
    bus.in_valid   = 1'b1;
    bus.div_signed = s;
    bus.div_word   = w;
    bus.x          = a;
    bus.y          = b;
    if (track) sb.push_back('{q, r, lat, cyc});
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.div_signed = 1'($urandom_range(0, 1));
    bus.div_word   = 1'($urandom_range(0, 1));
    bus.x          = {$urandom, $urandom};
    bus.y          = {$urandom, $urandom};
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain got=%0d exp=0 pending", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_wait got=out_valid_low exp=out_valid_high", name);
    end
  endtask

  task automatic addv(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] q, input logic [63:0] r, input int lat);
    vecs.push_back('{s, w, a, b, q, r, lat});
  endtask

  initial begin
    logic        s, w;
    logic [63:0] a, b, q, r, sq, sr;
    int          lat, k;

    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_word = 1'b0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quo", bus.quo, 0);
    chk("rst_rem", bus.rem, 0);
    reset = 1'b0;
    @(negedge clk);

    // s, w, x, y, quo, rem, latency
    addv(0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    addv(1, 0, -64'sd7, 64'd2, -64'sd3, -64'sd1, 65);
    addv(1, 0, 64'd7, -64'sd2, -64'sd3, 64'd1, 65);
    addv(1, 0, 64'h1234, 64'd0, '1, 64'h1234, 1);
    addv(1, 1, 64'h8000_0000, 64'd0, '1, 64'hFFFF_FFFF_8000_0000, 1);
    addv(0, 1, 64'h8000_0000, 64'd0, '1, 64'hFFFF_FFFF_8000_0000, 1);
    addv(1, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 1);
    addv(1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    addv(0, 1, 64'hFFFF_FFFF, 64'd1, '1, 64'd0, 33);
    addv(0, 1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 33);
    addv(0, 0, '1, 64'd1, '1, 64'd0, 65);
    addv(0, 0, '1, '1, 64'd1, 64'd0, 65);
    addv(1, 1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_0000_0000_0002, -64'sd3, -64'sd1, 33);
    addv(0, 1, 64'h0000_0001_0000_0010, 64'h0000_0005_0000_0003, 64'd5, 64'd1, 33);
    addv(0, 0, 64'd5, 64'd10, 64'd0, 64'd5, 65);
    addv(1, 0, -64'sd8, -64'sd3, 64'd2, -64'sd2, 65);
    addv(0, 1, 64'h8000_0000, 64'd2, 64'h4000_0000, 64'd0, 33);

    rdy_mode = 1;
    for (int i = 0; i < vecs.size(); i++)
      issue(vecs[i].s, vecs[i].w, vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].lat, 1'b1);
    drain("table");

    // result held stable while the consumer stalls
    rdy_mode = 0;
    issue(0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 1'b1);
    wait_valid("stall");
    sq = bus.quo;
    sr = bus.rem;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_quo", bus.quo, sq);
      chk("stall_rem", bus.rem, sr);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
    end
    rdy_mode = 1;
    drain("stall");

    // flush mid-CALC discards the op; the next op is unaffected
    issue(0, 0, 64'd1000, 64'd3, 64'd0, 64'd0, 0, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_out_valid", bus.out_valid, 0);
    repeat (70) @(negedge clk);
    issue(1, 0, -64'sd7, 64'd2, -64'sd3, -64'sd1, 65, 1'b1);
    drain("after_flush");

    // in_valid together with flush is ignored
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_word = 1'b0;
    bus.x = 64'd5;
    bus.y = 64'd0;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_accept_in_ready", bus.in_ready, 1);
    repeat (5) @(negedge clk);

    // reset while a result is waiting clears the outputs
    rdy_mode = 0;
    issue(1, 0, 64'h55, 64'd0, '1, 64'h55, 1, 1'b1);
    wait_valid("reset_mid");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("reset_mid_quo", bus.quo, 0);
    chk("reset_mid_rem", bus.rem, 0);
    chk("reset_mid_out_valid", bus.out_valid, 0);
    chk("reset_mid_in_ready", bus.in_ready, 1);
    rdy_mode = 1;
    @(negedge clk);

    // random ops against the reference model with consumer stalls
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      a = a >> $urandom_range(0, 63);
      b = b >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 3) == 0) b = -b;
      k = $urandom_range(0, 15);
      if (k == 0) b = '0;
      else if (k == 1) begin a = 64'h8000_0000_0000_0000; b = '1; end
      else if (k == 2) begin a = 64'h8000_0000; b = 64'hFFFF_FFFF; end
      ref_div(s, w, a, b, q, r, lat);
      issue(s, w, a, b, q, r, lat, 1'b1);
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
